// File: rtl/svp_pkg.sv
// -----------------------------------------------------------------------------
// svp_pkg
// Shared definitions for the stereo vision processor disparity path.
//   - Default geometry of the disparity output stream and derived counts.
//   - dis_slot_t: one result slot as written into the disparity FIFO by
//     stereo_match (upper fields, match flag, disparity).
//   - dis_sanitise(): maps one slot to the pixel value sent downstream.
// -----------------------------------------------------------------------------
package svp_pkg;

  // Default stream geometry.
  localparam int DIS_COLS        = 1280;
  localparam int DIS_BEAT_SIZE   = 8;
  localparam int DIS_DATA_WIDTH  = 16;
  localparam int DIS_ISSUE_WIDTH = 2;
  localparam int DIS_USER_WIDTH  = (DIS_DATA_WIDTH + 1) * 3;

  localparam int SLOTS_PER_BEAT  = DIS_BEAT_SIZE / DIS_ISSUE_WIDTH;
  localparam int BEATS_PER_ROW   = DIS_COLS / DIS_BEAT_SIZE;

  // Bits of a slot above the match flag; carried along but ignored here.
  localparam int DIS_UPPER_WIDTH = DIS_USER_WIDTH - DIS_DATA_WIDTH - 1;

  // Signed fixed point, 8 fractional bits.
  typedef logic [DIS_DATA_WIDTH-1:0] dis_pix_t;

  typedef struct packed {
    logic [DIS_UPPER_WIDTH-1:0] upper;
    logic                       match;
    dis_pix_t                   disparity;
  } dis_slot_t;

  // Unmatched results become invalid_val; negative disparities clamp to 0.
  function automatic dis_pix_t dis_sanitise(input dis_slot_t slot,
                                            input dis_pix_t  invalid_val);
    dis_pix_t pix;
    if (!slot.match) begin
      pix = invalid_val;
    end else if (slot.disparity[DIS_DATA_WIDTH-1]) begin
      pix = '0;
    end else begin
      pix = slot.disparity;
    end
    return pix;
  endfunction

endpackage

// File: rtl/dis_stream_packer_sanitise.sv
// -----------------------------------------------------------------------------
// dis_lane_sanitise
// Purely combinational clean-up of one disparity FIFO result slot.
// Ports:
//   slot   in   dis_slot_t  raw result slot from the FIFO head
//   pixel  out  dis_pix_t   sanitised pixel for one output lane
// Parameter:
//   INVALID_VAL  pixel emitted for unmatched results
// -----------------------------------------------------------------------------
module dis_lane_sanitise
  import svp_pkg::*;
#(
  parameter dis_pix_t INVALID_VAL = '0
) (
  input  dis_slot_t slot,
  output dis_pix_t  pixel
);

  assign pixel = dis_sanitise(slot, INVALID_VAL);

endmodule

// File: rtl/dis_stream_packer.sv
// -----------------------------------------------------------------------------
// dis_stream_packer
// Read side of the disparity FIFO. Pops ISSUE_WIDTH results per FIFO entry,
// sanitises them, packs BEAT_SIZE pixels into one AXI-Stream beat and flags
// the last beat of every image row with tlast. Mirror image of input_control.
//
// Ports:
//   aclk, aresetn   clock, asynchronous active-low reset
//   dis_buf_dout    FWFT FIFO head, slot k at [k*USER_WIDTH +: USER_WIDTH]
//   dis_buf_empty   FIFO empty
//   dis_buf_rd_en   FIFO pop (combinational, same-cycle)
//   m_axis_tdata    output beat, lane 0 (lowest column) at the LSBs
//   m_axis_tvalid   beat valid
//   m_axis_tready   downstream ready
//   m_axis_tlast    last beat of a row
//   m_axis_tuser    start of frame (only with DIS_PACK_SOF_EN)
//
// Build option: define DIS_PACK_SOF_EN to add the ROWS parameter, a row
// counter and the m_axis_tuser start-of-frame flag.
// -----------------------------------------------------------------------------
module dis_stream_packer
  import svp_pkg::*;
#(
  parameter int                    COLS        = DIS_COLS,
  parameter int                    BEAT_SIZE   = DIS_BEAT_SIZE,
  parameter int                    DATA_WIDTH  = DIS_DATA_WIDTH,
  parameter int                    ISSUE_WIDTH = DIS_ISSUE_WIDTH,
  parameter int                    USER_WIDTH  = (DATA_WIDTH + 1) * 3,
  parameter logic [DATA_WIDTH-1:0] INVALID_VAL = '0
`ifdef DIS_PACK_SOF_EN
  ,
  parameter int                    ROWS        = 1024
`endif
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic [ISSUE_WIDTH*USER_WIDTH-1:0]   dis_buf_dout,
  input  logic                                dis_buf_empty,
  output logic                                dis_buf_rd_en,
  output logic [BEAT_SIZE*DATA_WIDTH-1:0]     m_axis_tdata,
  output logic                                m_axis_tvalid,
  output logic                                m_axis_tlast,
`ifdef DIS_PACK_SOF_EN
  output logic                                m_axis_tuser,
`endif
  input  logic                                m_axis_tready
);

  localparam int SPB     = BEAT_SIZE / ISSUE_WIDTH;
  localparam int SLOT_W  = (SPB > 1) ? $clog2(SPB) : 1;
  localparam int COL_W   = $clog2(COLS + 1);
  localparam int ENTRY_W = ISSUE_WIDTH * DATA_WIDTH;
  localparam int BEAT_W  = BEAT_SIZE * DATA_WIDTH;

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SPB - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - BEAT_SIZE);
  localparam logic [COL_W-1:0]  COL_STEP  = COL_W'(BEAT_SIZE);

  // Slot layout is shared with stereo_match through dis_slot_t, so the
  // widths must agree with the package; geometry must divide evenly.
  if (DATA_WIDTH != DIS_DATA_WIDTH || USER_WIDTH != DIS_USER_WIDTH) begin : g_bad_width
    $error("dis_stream_packer: DATA_WIDTH/USER_WIDTH must match svp_pkg::dis_slot_t");
  end
  if ((BEAT_SIZE % ISSUE_WIDTH) != 0 || (COLS % BEAT_SIZE) != 0) begin : g_bad_geom
    $error("dis_stream_packer: COLS %% BEAT_SIZE and BEAT_SIZE %% ISSUE_WIDTH must be 0");
  end

  // ---------------------------------------------------------------------------
  // Per-slot sanitise of the FIFO head.
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0] entry_pix;

  for (genvar k = 0; k < ISSUE_WIDTH; k++) begin : g_lane
    dis_slot_t slot;
    assign slot = dis_buf_dout[k*USER_WIDTH +: USER_WIDTH];

    dis_lane_sanitise #(
      .INVALID_VAL (INVALID_VAL)
    ) u_sanitise (
      .slot  (slot),
      .pixel (entry_pix[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // ---------------------------------------------------------------------------
  // Pop decision. The last slot of a beat may only be popped when the output
  // register is free this cycle, so a completed beat never has to wait inside
  // the accumulator; earlier slots pop whenever data is available.
  // ---------------------------------------------------------------------------
  logic [BEAT_W-1:0] acc;
  logic [SLOT_W-1:0] slot_cnt;
  logic [COL_W-1:0]  col_cnt;

  logic last_slot;
  logic out_free;
  logic pop;
  logic full_next;
  logic row_end;

  assign last_slot = (slot_cnt == LAST_SLOT);
  assign out_free  = !m_axis_tvalid || m_axis_tready;
  // Held low during reset so nothing is drained from the FIFO while the
  // accumulator is being cleared.
  assign pop       = aresetn && !dis_buf_empty && (!last_slot || out_free);
  assign full_next = pop && last_slot;
  assign row_end   = (col_cnt == LAST_COL);

  assign dis_buf_rd_en = pop;

  // Accumulator contents with the current FIFO entry merged into its lanes.
  logic [BEAT_W-1:0] beat_next;

  // NOTE: every always_comb output gets a full default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    beat_next = acc;
    beat_next[slot_cnt*ENTRY_W +: ENTRY_W] = entry_pix;
  end

`ifdef DIS_PACK_SOF_EN
  localparam int               ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  logic [ROW_W-1:0] row_cnt;
`endif

  // ---------------------------------------------------------------------------
  // Accumulator, counters and the AXI-Stream output register.
  // ---------------------------------------------------------------------------
  // NOTE: the accumulator is ordinary flops rather than a RAM, so it is reset
  // with everything else; a reset mid-row therefore discards the partial beat.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc           <= '0;
      slot_cnt      <= '0;
      col_cnt       <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
`ifdef DIS_PACK_SOF_EN
      m_axis_tuser  <= 1'b0;
      row_cnt       <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every right-hand side
      // reads the pre-edge value regardless of statement order.
      if (pop) begin
        acc      <= beat_next;
        slot_cnt <= last_slot ? '0 : slot_cnt + SLOT_W'(1);
      end

      if (full_next) begin
        // A new beat may replace one being accepted this very cycle, which
        // keeps the stream gap-free under continuous tready.
        m_axis_tdata  <= beat_next;
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= row_end;
        col_cnt       <= row_end ? '0 : col_cnt + COL_STEP;
`ifdef DIS_PACK_SOF_EN
        m_axis_tuser  <= (row_cnt == '0) && (col_cnt == '0);
        if (row_end) begin
          row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + ROW_W'(1);
        end
`endif
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dis_stream_packer.sv
// -----------------------------------------------------------------------------
// tb_dis_stream_packer
// Self-checking bench for dis_stream_packer. A queue stands in for the FWFT
// disparity FIFO. The reference model works at stream level: every popped
// slot is sanitised into a list of expected pixels, beats are consecutive
// groups of BEAT_SIZE pixels, and beat n of an epoch (since reset) ends a row
// when n mod BEATS_PER_ROW is the last index. The expected pop/valid
// behaviour is derived from the count of popped entries and accepted beats.
// -----------------------------------------------------------------------------
module tb_dis_stream_packer;
  import svp_pkg::*;

  localparam int COLS = DIS_COLS;
  localparam int BEAT = DIS_BEAT_SIZE;
  localparam int DW   = DIS_DATA_WIDTH;
  localparam int IW   = DIS_ISSUE_WIDTH;
  localparam int UW   = DIS_USER_WIDTH;
  localparam int SPB  = SLOTS_PER_BEAT;
  localparam int BPR  = BEATS_PER_ROW;
  localparam int BW   = BEAT * DW;
`ifdef DIS_PACK_SOF_EN
  localparam int TB_ROWS = 2;
`endif

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic [IW*UW-1:0]  dis_buf_dout = '0;
  logic              dis_buf_empty = 1'b1;
  logic              dis_buf_rd_en;
  logic [BW-1:0]     m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready = 1'b1;
`ifdef DIS_PACK_SOF_EN
  logic              m_axis_tuser;
`endif

  dis_stream_packer #(
    .COLS        (COLS),
    .BEAT_SIZE   (BEAT),
    .DATA_WIDTH  (DW),
    .ISSUE_WIDTH (IW),
    .USER_WIDTH  (UW),
    .INVALID_VAL (16'h0000)
`ifdef DIS_PACK_SOF_EN
    ,
    .ROWS        (TB_ROWS)
`endif
  ) u_dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .dis_buf_dout  (dis_buf_dout),
    .dis_buf_empty (dis_buf_empty),
    .dis_buf_rd_en (dis_buf_rd_en),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
`ifdef DIS_PACK_SOF_EN
    .m_axis_tuser  (m_axis_tuser),
`endif
    .m_axis_tready (m_axis_tready)
  );

  always #5 aclk = ~aclk;

  // ---------------------------------------------------------------------------
  // Bench state
  // ---------------------------------------------------------------------------
  logic [IW*UW-1:0] fifo[$];
  logic [DW-1:0]    exp_pix[$];
  logic [BW-1:0]    got_beats[$];
  logic             got_last[$];
  int               acc_cyc[$];
  int               pops, accepted, cyc;
  int               total, bad;
  bit               stall;

  typedef struct {
    logic          match;
    logic [DW-1:0] disp;
    logic [DW-1:0] expect_pix;
  } san_vec_t;

  task automatic check(input string name, input logic [BW-1:0] act,
                       input logic [BW-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Spec rule: unmatched -> 0 (INVALID_VAL), negative -> 0, else unchanged.
  function automatic logic [DW-1:0] ref_pixel(input logic [UW-1:0] s);
    logic          match;
    logic [DW-1:0] d;
    match = s[DW];
    d     = s[DW-1:0];
    if (!match) return 16'h0000;
    if ($signed(d) < 0) return 16'h0000;
    return d;
  endfunction

  function automatic logic [UW-1:0] make_slot(input logic m, input logic [DW-1:0] d);
    logic [UW-1:0] s;
    s        = UW'({$urandom(), $urandom()});  // junk in the ignored upper bits
    s[DW]    = m;
    s[DW-1:0] = d;
    return s;
  endfunction

  function automatic logic [DW-1:0] lane(input logic [BW-1:0] b, input int i);
    return b[i*DW +: DW];
  endfunction

  function automatic logic [BW-1:0] model_front_beat();
    logic [BW-1:0] b;
    b = '0;
    for (int i = 0; i < BEAT; i++) b[i*DW +: DW] = exp_pix[i];
    return b;
  endfunction

  task automatic push_entry(input logic [UW-1:0] s0, input logic [UW-1:0] s1);
    fifo.push_back({s1, s0});
  endtask

  task automatic push_random(input int n, input bit any);
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] d0, d1;
      logic m0, m1;
      d0 = DW'($urandom());
      d1 = DW'($urandom());
      m0 = any ? 1'($urandom_range(0, 1)) : 1'b1;
      m1 = any ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!any) begin
        d0[DW-1] = 1'b0;
        d1[DW-1] = 1'b0;
      end
      push_entry(make_slot(m0, d0), make_slot(m1, d1));
    end
  endtask

  task automatic update_inputs();
    dis_buf_empty = (fifo.size() == 0) || stall;
    dis_buf_dout  = (fifo.size() != 0) ? fifo[0] : '0;
  endtask

  task automatic model_reset();
    exp_pix.delete();
    pops     = 0;
    accepted = 0;
  endtask

  // One clock cycle: called at a falling edge with reset released.
  task automatic cycle();
    int            outstanding;
    logic          exp_valid, exp_rd;
    logic [BW-1:0] eb;
    logic [IW*UW-1:0] e;
    update_inputs();
    #1;
    outstanding = pops / SPB - accepted;
    exp_valid   = (outstanding > 0);
    exp_rd      = !dis_buf_empty &&
                  (((pops % SPB) != SPB - 1) || !exp_valid || m_axis_tready);
    check("tvalid", BW'(m_axis_tvalid), BW'(exp_valid));
    check("rd_en", BW'(dis_buf_rd_en), BW'(exp_rd));
    if (m_axis_tvalid && m_axis_tready && exp_pix.size() >= BEAT) begin
      eb = model_front_beat();
      for (int i = 0; i < BEAT; i++) void'(exp_pix.pop_front());
      check("tdata", m_axis_tdata, eb);
      check("tlast", BW'(m_axis_tlast), BW'((accepted % BPR) == BPR - 1));
`ifdef DIS_PACK_SOF_EN
      check("tuser", BW'(m_axis_tuser), BW'((accepted % (BPR * TB_ROWS)) == 0));
`endif
      got_beats.push_back(m_axis_tdata);
      got_last.push_back(m_axis_tlast);
      acc_cyc.push_back(cyc);
      accepted++;
    end
    if (dis_buf_rd_en && !dis_buf_empty) begin
      e = fifo.pop_front();
      for (int k = 0; k < IW; k++) exp_pix.push_back(ref_pixel(e[k*UW +: UW]));
      pops++;
    end
    @(posedge aclk);
    cyc++;
    @(negedge aclk);
  endtask

  task automatic drain(input int bound, input bit rnd);
    int n;
    n = 0;
    while ((fifo.size() != 0 || pops / SPB > accepted) && n < bound) begin
      if (rnd) begin
        stall         = ($urandom_range(0, 9) < 3);
        m_axis_tready = ($urandom_range(0, 9) < 6);
      end
      cycle();
      n++;
    end
    stall = 1'b0;
    check("drain_done", BW'(n < bound), BW'(1));
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    model_reset();
    got_beats.delete();
    got_last.delete();
    acc_cyc.delete();
  endtask

  function automatic int count_last();
    int c;
    c = 0;
    foreach (got_last[i]) if (got_last[i]) c++;
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    san_vec_t tv[8];
    int       max_gap;

    total = 0; bad = 0; cyc = 0; stall = 1'b0;
    model_reset();

    // Reset state, with a non-empty FIFO so a pop would be visible.
    push_entry(make_slot(1'b1, 16'h0011), make_slot(1'b1, 16'h0022));
    update_inputs();
    #3;
    check("rst_rd_en", BW'(dis_buf_rd_en), BW'(0));
    check("rst_tvalid", BW'(m_axis_tvalid), BW'(0));
    check("rst_tdata", m_axis_tdata, '0);
    check("rst_tlast", BW'(m_axis_tlast), BW'(0));
`ifdef DIS_PACK_SOF_EN
    check("rst_tuser", BW'(m_axis_tuser), BW'(0));
`endif
    fifo.delete();
    update_inputs();
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    model_reset();

    // Basic beat: disparities 1..8, all matched.
    for (int e = 0; e < SPB; e++)
      push_entry(make_slot(1'b1, DW'(2*e + 1)), make_slot(1'b1, DW'(2*e + 2)));
    m_axis_tready = 1'b1;
    drain(50, 1'b0);
    check("basic_count", BW'(got_beats.size()), BW'(1));
    if (got_beats.size() == 1) begin
      for (int i = 0; i < BEAT; i++)
        check($sformatf("basic_lane%0d", i), BW'(lane(got_beats[0], i)), BW'(i + 1));
      check("basic_tlast", BW'(got_last[0]), BW'(0));
    end

    // Table-driven sanitise vectors, one beat's worth.
    tv[0] = '{1'b0, 16'h0123, 16'h0000};
    tv[1] = '{1'b1, 16'h8005, 16'h0000};
    tv[2] = '{1'b1, 16'h00A0, 16'h00A0};
    tv[3] = '{1'b1, 16'h7FFF, 16'h7FFF};
    tv[4] = '{1'b1, 16'hFFFF, 16'h0000};
    tv[5] = '{1'b0, 16'h8000, 16'h0000};
    tv[6] = '{1'b1, 16'h0000, 16'h0000};
    tv[7] = '{1'b1, 16'h0001, 16'h0001};
    for (int e = 0; e < SPB; e++)
      push_entry(make_slot(tv[2*e].match, tv[2*e].disp),
                 make_slot(tv[2*e+1].match, tv[2*e+1].disp));
    drain(50, 1'b0);
    check("table_count", BW'(got_beats.size()), BW'(2));
    if (got_beats.size() == 2)
      for (int i = 0; i < BEAT; i++)
        check($sformatf("table_lane%0d", i), BW'(lane(got_beats[1], i)),
              BW'(tv[i].expect_pix));

    // Full row with continuous ready: 160 beats, no gaps, tlast on the last.
    do_reset();
    push_random(COLS / IW, 1'b0);
    drain(2000, 1'b0);
    check("row_beats", BW'(got_beats.size()), BW'(BPR));
    check("row_tlast_count", BW'(count_last()), BW'(1));
    if (got_last.size() == BPR) check("row_tlast_pos", BW'(got_last[BPR-1]), BW'(1));
    max_gap = 0;
    for (int i = 1; i < acc_cyc.size(); i++)
      if (acc_cyc[i] - acc_cyc[i-1] > max_gap) max_gap = acc_cyc[i] - acc_cyc[i-1];
    check("row_max_gap", BW'(max_gap), BW'(SPB));

    // Backpressure: tready low for 20 cycles with plenty in the FIFO.
    do_reset();
    push_random(4 * SPB, 1'b1);
    m_axis_tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (m_axis_tvalid) check("hold_tdata", m_axis_tdata, model_front_beat());
    end
    // One beat held in the output register plus SPB-1 slots accumulated.
    check("hold_fifo_left", BW'(fifo.size()), BW'(4 * SPB - (2 * SPB - 1)));
    m_axis_tready = 1'b1;
    drain(200, 1'b0);
    check("hold_beats", BW'(got_beats.size()), BW'(4));

    // Reset in the middle of a beat while an output beat is pending.
    do_reset();
    push_random(SPB + 2, 1'b1);
    m_axis_tready = 1'b0;
    for (int i = 0; i < 8; i++) cycle();
    #2;
    aresetn = 1'b0;
    #1;
    check("midrst_tvalid", BW'(m_axis_tvalid), BW'(0));
    check("midrst_tdata", m_axis_tdata, '0);
    check("midrst_tlast", BW'(m_axis_tlast), BW'(0));
    @(negedge aclk);
    aresetn = 1'b1;
    model_reset();
    got_beats.delete(); got_last.delete(); acc_cyc.delete();
    fifo.delete();
    m_axis_tready = 1'b1;
    push_random(COLS / IW, 1'b1);
    drain(2000, 1'b0);
    check("midrst_beats", BW'(got_beats.size()), BW'(BPR));
    check("midrst_tlast_count", BW'(count_last()), BW'(1));

    // Randomised traffic: FIFO gaps, random ready, random slot contents.
    do_reset();
    push_random(1000, 1'b1);
    drain(20000, 1'b1);
    m_axis_tready = 1'b1;
    check("rand_beats", BW'(got_beats.size()), BW'(1000 / SPB));
    check("rand_tlast_count", BW'(count_last()), BW'((1000 / SPB) / BPR));

`ifdef DIS_PACK_SOF_EN
    // Frames of TB_ROWS rows: start of frame on beat 0 and on beat 2*BPR.
    do_reset();
    push_random(2 * BPR * SPB + SPB, 1'b1);
    drain(4000, 1'b0);
    check("sof_beats", BW'(got_beats.size()), BW'(2 * BPR + 1));
    check("sof_tlast_count", BW'(count_last()), BW'(2));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
